sysid_check_master: RTL and testbench

- Avalon-MM read master that sits directly upstream of the system-ID slave and consumes its readdata.
- After reset, or on request, it reads word 0 (system ID) and word 1 (build timestamp), then compares both against build-time expected values.
- Drives status flags to the boot/LED logic and can raise an interrupt to the Nios II on mismatch, so a stale or mismatched FPGA image is caught before software runs.

---
 rtl/sysid_check_master_if.sv | 37 +++
 rtl/sysid_check_master.sv | 263 ++++++++++++++++++++++++++
 tb/tb_sysid_check_master.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sysid_check_master_if.sv
// -----------------------------------------------------------------------------
// sysid_check_master_if
//
// Purpose:
//   Avalon-MM read-only link between sysid_check_master and the system-ID
//   slave. Only the signals a zero-latency read slave needs are carried.
//
// Signals:
//   avm_address      word address (0 = system ID, 1 = build timestamp)
//   avm_read         read strobe, held for the whole transfer
//   avm_waitrequest  slave stall; transfer completes when it is low with read
//   avm_readdata     read data, valid on the completing cycle
//
// Modports:
//   master  - driven by sysid_check_master
//   slave   - driven by the system-ID slave (or a bench model)
// -----------------------------------------------------------------------------
interface sysid_check_master_if;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );
endinterface

// File: rtl/sysid_check_master.sv
// -----------------------------------------------------------------------------
// sysid_check_master
//
// Purpose:
//   Avalon-MM read master placed in front of the system-ID slave. After reset
//   (when AUTO_START=1) or on a start pulse it reads word 0 (system ID) and
//   word 1 (build timestamp), compares both against build-time constants and
//   reports the outcome through sticky status flags and an optional interrupt,
//   so a stale or mismatched FPGA image is flagged before software runs.
//
// Parameters:
//   EXPECTED_ID         expected word 0
//   EXPECTED_TIMESTAMP  expected word 1
//   TIMEOUT_CYCLES      stalled cycles allowed per read before aborting (1..255)
//   AUTO_START          1: launch a check on the first cycle after reset release
//
// Ports:
//   clock      system clock
//   reset_n    asynchronous active-low reset
//   start      single-cycle request for a new check (ignored while busy)
//   irq_ack    single-cycle pulse clearing irq
//   avm        Avalon-MM master side (sysid_check_master_if.master)
//   busy       check in progress
//   done       sticky, check finished (pass, fail or timeout)
//   id_ok      sticky, both words matched
//   mismatch   sticky, at least one word differed
//   timeout    sticky, check aborted on waitrequest timeout
//   id_value   captured word 0
//   ts_value   captured word 1
//   irq        mismatch/timeout interrupt
//
// Build option:
//   SYSID_CHECK_IRQ_EN  when defined, irq is a sticky register set at the end
//                       of a failed or timed-out check and cleared by irq_ack.
//                       When undefined, irq is constant 0 and irq_ack unused.
// -----------------------------------------------------------------------------
module sysid_check_master #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1427243257,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter int          AUTO_START         = 1
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic                        irq_ack,
    sysid_check_master_if.master        avm,
    output logic                        busy,
    output logic                        done,
    output logic                        id_ok,
    output logic                        mismatch,
    output logic                        timeout,
    output logic [31:0]                 id_value,
    output logic [31:0]                 ts_value,
    output logic                        irq
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_ID = 3'd1,
        RD_TS = 3'd2,
        EVAL  = 3'd3,
        FIN   = 3'd4
    } state_t;

    // The abort fires on the last permitted stalled cycle, so avm_read is
    // high for exactly TIMEOUT_CYCLES stalled cycles before it drops.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;

    logic        first_cycle;
    logic [7:0]  timeout_cnt;

    logic        rd_addr;
    logic        rd_strobe;
    logic        launch;
    logic        cap_id;
    logic        cap_ts;
    logic        cnt_clr;
    logic        cnt_inc;
    logic        abort;
    logic        eval_en;
    logic        fin_en;
    logic        auto_go;
    logic        words_match;

    assign avm.avm_address = rd_addr;
    assign avm.avm_read    = rd_strobe;

    // Auto-start fires only on the very first clock after reset release.
    assign auto_go     = (AUTO_START != 0) && first_cycle;
    assign words_match = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TIMESTAMP);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and bus strobes. Address and read depend only on the state,
    // so they cannot change while the slave holds waitrequest high.
    always_comb begin
        state_next = state;
        rd_addr    = 1'b0;
        rd_strobe  = 1'b0;
        launch     = 1'b0;
        cap_id     = 1'b0;
        cap_ts     = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        abort      = 1'b0;
        eval_en    = 1'b0;
        fin_en     = 1'b0;

        case (state)
            IDLE: begin
                if (start || auto_go) begin
                    launch     = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = RD_ID;
                end
            end

            RD_ID: begin
                rd_addr   = 1'b0;
                rd_strobe = 1'b1;
                if (!avm.avm_waitrequest) begin
                    cap_id     = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = RD_TS;
                end else if (timeout_cnt == TIMEOUT_LAST) begin
                    abort      = 1'b1;
                    state_next = FIN;
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            RD_TS: begin
                rd_addr   = 1'b1;
                rd_strobe = 1'b1;
                if (!avm.avm_waitrequest) begin
                    cap_ts     = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = EVAL;
                end else if (timeout_cnt == TIMEOUT_LAST) begin
                    abort      = 1'b1;
                    state_next = FIN;
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            EVAL: begin
                eval_en    = 1'b1;
                state_next = FIN;
            end

            FIN: begin
                fin_en     = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // First-cycle marker used for auto-start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            first_cycle <= 1'b1;
        end else begin
            first_cycle <= 1'b0;
        end
    end

    // Per-read stall counter, cleared when a read begins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timeout_cnt <= 8'd0;
        end else if (cnt_clr) begin
            timeout_cnt <= 8'd0;
        end else if (cnt_inc) begin
            timeout_cnt <= timeout_cnt + 8'd1;
        end
    end

    // Captured words. A timed-out check keeps whatever was captured before.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            id_value <= 32'd0;
            ts_value <= 32'd0;
        end else begin
            if (cap_id) begin
                id_value <= avm.avm_readdata;
            end
            if (cap_ts) begin
                ts_value <= avm.avm_readdata;
            end
        end
    end

    // Busy and sticky status flags. Flags are cleared when a check launches
    // and only otherwise change on abort, EVAL or FIN.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            id_ok    <= 1'b0;
            mismatch <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            if (launch) begin
                busy     <= 1'b1;
                done     <= 1'b0;
                id_ok    <= 1'b0;
                mismatch <= 1'b0;
                timeout  <= 1'b0;
            end
            if (abort) begin
                timeout <= 1'b1;
            end
            if (eval_en) begin
                id_ok    <= words_match;
                mismatch <= !words_match;
            end
            if (fin_en) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

`ifdef SYSID_CHECK_IRQ_EN
    logic irq_q;

    // Interrupt latch: a failing FIN sets it and wins over a same-cycle ack.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else if (fin_en && (mismatch || timeout)) begin
            irq_q <= 1'b1;
        end else if (irq_ack) begin
            irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`else
    logic unused_irq_ack;

    assign unused_irq_ack = irq_ack;
    assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_sysid_check_master.sv
// -----------------------------------------------------------------------------
// tb_sysid_check_master
//
// Purpose:
//   Directed self-checking bench for sysid_check_master. The main instance
//   (dut) uses AUTO_START=1 and TIMEOUT_CYCLES=8 behind a configurable
//   zero-latency slave model; a second instance (dut2) uses AUTO_START=0
//   behind an always-ready slave holding the expected words.
// -----------------------------------------------------------------------------
module tb_sysid_check_master;

    localparam logic [31:0] TS_GOOD = 32'd1427243257;

`ifdef SYSID_CHECK_IRQ_EN
    localparam logic IRQ_EXP = 1'b1;
`else
    localparam logic IRQ_EXP = 1'b0;
`endif

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        irq_ack;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        mismatch;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic        irq;

    logic        start2;
    logic        busy2;
    logic        done2;
    logic        id_ok2;
    logic        mismatch2;
    logic        timeout2;
    logic [31:0] id_value2;
    logic [31:0] ts_value2;
    logic        irq2;

    logic [31:0] id_word;
    logic [31:0] ts_word;
    int          stall_cfg;
    int          stall_cnt;
    int          rd_count;

    int          total;
    int          passed;

    sysid_check_master_if bus ();
    sysid_check_master_if bus2 ();

    sysid_check_master #(
        .EXPECTED_ID        (32'd0),
        .EXPECTED_TIMESTAMP (TS_GOOD),
        .TIMEOUT_CYCLES     (8),
        .AUTO_START         (1)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .irq_ack  (irq_ack),
        .avm      (bus),
        .busy     (busy),
        .done     (done),
        .id_ok    (id_ok),
        .mismatch (mismatch),
        .timeout  (timeout),
        .id_value (id_value),
        .ts_value (ts_value),
        .irq      (irq)
    );

    sysid_check_master #(
        .EXPECTED_ID        (32'd0),
        .EXPECTED_TIMESTAMP (TS_GOOD),
        .TIMEOUT_CYCLES     (8),
        .AUTO_START         (0)
    ) dut2 (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start2),
        .irq_ack  (1'b0),
        .avm      (bus2),
        .busy     (busy2),
        .done     (done2),
        .id_ok    (id_ok2),
        .mismatch (mismatch2),
        .timeout  (timeout2),
        .id_value (id_value2),
        .ts_value (ts_value2),
        .irq      (irq2)
    );

    // Slave model for dut: stalls stall_cfg cycles per read, zero read latency.
    assign bus.avm_waitrequest = bus.avm_read && (stall_cnt < stall_cfg);
    assign bus.avm_readdata    = bus.avm_address ? ts_word : id_word;

    // Always-ready slave for dut2.
    assign bus2.avm_waitrequest = 1'b0;
    assign bus2.avm_readdata    = bus2.avm_address ? TS_GOOD : 32'd0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Stall counter for the slave model and a count of completed dut reads.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= 0;
            rd_count  <= 0;
        end else begin
            if (bus.avm_read && bus.avm_waitrequest) begin
                stall_cnt <= stall_cnt + 1;
            end else begin
                stall_cnt <= 0;
            end
            if (bus.avm_read && !bus.avm_waitrequest) begin
                rd_count <= rd_count + 1;
            end
        end
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic applyStimulus();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        start2    = 1'b0;
        irq_ack   = 1'b0;
        id_word   = 32'd0;
        ts_word   = TS_GOOD;
        stall_cfg = 0;
        repeat (3) step();

        $display("[TB] reset state");
        checkOutput("rst_read", 32'(bus.avm_read), 32'd0);
        checkOutput("rst_addr", 32'(bus.avm_address), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_flags", {29'd0, id_ok, mismatch, timeout}, 32'd0);
        checkOutput("rst_id_value", id_value, 32'd0);
        checkOutput("rst_ts_value", ts_value, 32'd0);
        checkOutput("rst_irq", 32'(irq), 32'd0);
        checkOutput("rst_read2", 32'(bus2.avm_read), 32'd0);

        $display("[TB] auto-start after release, start during busy ignored");
        reset_n = 1'b1;
        step();
        checkOutput("auto_read", 32'(bus.avm_read), 32'd1);
        checkOutput("auto_addr0", 32'(bus.avm_address), 32'd0);
        checkOutput("auto_busy", 32'(busy), 32'd1);
        applyStimulus();
        checkOutput("auto_addr1", 32'(bus.avm_address), 32'd1);
        checkOutput("auto_read_ts", 32'(bus.avm_read), 32'd1);
        step();
        checkOutput("auto_read_drop", 32'(bus.avm_read), 32'd0);
        step();
        step();
        checkOutput("auto_done", 32'(done), 32'd1);
        checkOutput("auto_id_ok", 32'(id_ok), 32'd1);
        checkOutput("auto_busy_clr", 32'(busy), 32'd0);
        repeat (3) step();
        checkOutput("auto_no_requeue", 32'(bus.avm_read), 32'd0);
        checkOutput("auto_read_count", 32'(rd_count), 32'd2);
        checkOutput("no_auto2_read", 32'(bus2.avm_read), 32'd0);
        checkOutput("no_auto2_busy", 32'(busy2), 32'd0);

        $display("[TB] zero-wait pass");
        applyStimulus();
        checkOutput("zw_c1_read", 32'(bus.avm_read), 32'd1);
        checkOutput("zw_c1_addr", 32'(bus.avm_address), 32'd0);
        checkOutput("zw_c1_done_clr", 32'(done), 32'd0);
        step();
        checkOutput("zw_c2_read", 32'(bus.avm_read), 32'd1);
        checkOutput("zw_c2_addr", 32'(bus.avm_address), 32'd1);
        step();
        checkOutput("zw_c3_read", 32'(bus.avm_read), 32'd0);
        step();
        checkOutput("zw_c4_done", 32'(done), 32'd0);
        step();
        checkOutput("zw_c5_done", 32'(done), 32'd1);
        checkOutput("zw_id_ok", 32'(id_ok), 32'd1);
        checkOutput("zw_mismatch", 32'(mismatch), 32'd0);
        checkOutput("zw_irq", 32'(irq), 32'd0);
        checkOutput("zw_ts_value", ts_value, TS_GOOD);

        $display("[TB] timestamp mismatch");
        ts_word = 32'h12345678;
        applyStimulus();
        repeat (4) step();
        checkOutput("mm_done", 32'(done), 32'd1);
        checkOutput("mm_mismatch", 32'(mismatch), 32'd1);
        checkOutput("mm_id_ok", 32'(id_ok), 32'd0);
        checkOutput("mm_ts_value", ts_value, 32'h12345678);
        checkOutput("mm_irq", 32'(irq), 32'(IRQ_EXP));
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        checkOutput("mm_irq_acked", 32'(irq), 32'd0);

        $display("[TB] three stall cycles per read");
        ts_word   = TS_GOOD;
        stall_cfg = 3;
        applyStimulus();
        step();
        checkOutput("st_c2_read", 32'(bus.avm_read), 32'd1);
        checkOutput("st_c2_addr", 32'(bus.avm_address), 32'd0);
        checkOutput("st_c2_wait", 32'(bus.avm_waitrequest), 32'd1);
        step();
        step();
        checkOutput("st_c4_addr", 32'(bus.avm_address), 32'd0);
        checkOutput("st_c4_wait", 32'(bus.avm_waitrequest), 32'd0);
        step();
        checkOutput("st_c5_addr", 32'(bus.avm_address), 32'd1);
        checkOutput("st_c5_read", 32'(bus.avm_read), 32'd1);
        repeat (3) step();
        checkOutput("st_c8_read", 32'(bus.avm_read), 32'd1);
        checkOutput("st_c8_addr", 32'(bus.avm_address), 32'd1);
        step();
        checkOutput("st_c9_read", 32'(bus.avm_read), 32'd0);
        step();
        checkOutput("st_c10_done", 32'(done), 32'd0);
        step();
        checkOutput("st_c11_done", 32'(done), 32'd1);
        checkOutput("st_id_ok", 32'(id_ok), 32'd1);

        $display("[TB] waitrequest stuck high");
        stall_cfg = 1000;
        applyStimulus();
        repeat (7) step();
        checkOutput("to_c8_read", 32'(bus.avm_read), 32'd1);
        step();
        checkOutput("to_c9_read", 32'(bus.avm_read), 32'd0);
        step();
        checkOutput("to_done", 32'(done), 32'd1);
        checkOutput("to_timeout", 32'(timeout), 32'd1);
        checkOutput("to_id_ok", 32'(id_ok), 32'd0);
        checkOutput("to_mismatch", 32'(mismatch), 32'd0);
        checkOutput("to_irq", 32'(irq), 32'(IRQ_EXP));

        $display("[TB] start with irq_ack in the same cycle");
        stall_cfg = 0;
        start     = 1'b1;
        irq_ack   = 1'b1;
        step();
        start     = 1'b0;
        irq_ack   = 1'b0;
        checkOutput("sa_irq", 32'(irq), 32'd0);
        checkOutput("sa_busy", 32'(busy), 32'd1);
        checkOutput("sa_timeout_clr", 32'(timeout), 32'd0);
        repeat (4) step();
        checkOutput("sa_done", 32'(done), 32'd1);
        checkOutput("sa_id_ok", 32'(id_ok), 32'd1);

        $display("[TB] reset during the timestamp read");
        start  = 1'b1;
        start2 = 1'b1;
        step();
        start  = 1'b0;
        start2 = 1'b0;
        step();
        checkOutput("rr_pre_addr", 32'(bus.avm_address), 32'd1);
        checkOutput("rr_pre_read2", 32'(bus2.avm_read), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("rr_read", 32'(bus.avm_read), 32'd0);
        checkOutput("rr_busy", 32'(busy), 32'd0);
        checkOutput("rr_id_value", id_value, 32'd0);
        checkOutput("rr_ts_value", ts_value, 32'd0);
        checkOutput("rr_read2", 32'(bus2.avm_read), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        checkOutput("rr_auto_read", 32'(bus.avm_read), 32'd1);
        checkOutput("rr_idle_read2", 32'(bus2.avm_read), 32'd0);
        repeat (3) step();
        checkOutput("rr_idle2_read", 32'(bus2.avm_read), 32'd0);
        checkOutput("rr_idle2_busy", 32'(busy2), 32'd0);
        checkOutput("rr_idle2_done", 32'(done2), 32'd0);
        step();
        checkOutput("rr_auto_done", 32'(done), 32'd1);
        checkOutput("rr_auto_id_ok", 32'(id_ok), 32'd1);

        start2 = 1'b1;
        step();
        start2 = 1'b0;
        checkOutput("d2_read", 32'(bus2.avm_read), 32'd1);
        repeat (4) step();
        checkOutput("d2_done", 32'(done2), 32'd1);
        checkOutput("d2_id_ok", 32'(id_ok2), 32'd1);
        checkOutput("d2_ts_value", ts_value2, TS_GOOD);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
